// File: rtl/mux_scan_sequencer_if.sv
// Load handshake and mux-drive bundle between a word producer and the scan sequencer.
// The sequencer takes the slave side; the producer/mux side takes the master side.
interface mux_scan_sequencer_if #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) ();
    localparam int N = 2 ** SEL_W;

    logic [N-1:0]     data;
    logic [DIV_W-1:0] div;
    logic             load_valid;
    logic             load_ready;
    logic             hold;
    logic [N-1:0]     word;
    logic [SEL_W-1:0] sel;
    logic             str;
    logic             step;
    logic             done;
    logic             busy;

    modport master (
        output data, div, load_valid, hold,
        input  load_ready, word, sel, str, step, done, busy
    );

    modport slave (
        input  data, div, load_valid, hold,
        output load_ready, word, sel, str, step, done, busy
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Parallel-to-serial scan sequencer driving the select/strobe pins of a 2**SEL_W:1 mux.
// Accepts a word in IDLE, steps sel through every bit at div+1 clocks per bit, pulses done.
module mux_scan_sequencer #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_scan_sequencer_if.slave bus
);
    localparam int N = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     word_q, word_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic             str_q, str_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        step_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (bus.load_valid) begin
                    word_d  = bus.data;
                    div_d   = bus.div;
                    cnt_d   = bus.div;
                    step_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // cnt reloads at zero instead of wrapping, so a bit lasts div_q+1 cycles
                if (!bus.hold) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end else if (sel_q != SEL_LAST) begin
                        sel_d  = sel_q + SEL_W'(1);
                        cnt_d  = div_q;
                        step_d = 1'b1;
                    end else begin
                        sel_d   = '0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next-state decode.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        str_d   = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            str_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            step_q  <= step_d;
            done_q  <= done_d;
            str_q   <= str_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.word       = word_q;
    assign bus.sel        = sel_q;
    assign bus.str        = str_q;
    assign bus.step       = step_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: 8:1 and 4:1 instances against a bit-time model,
// plus directed scans with hand-computed timing and mux output sequences.
module tb_mux_scan_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mux_scan_sequencer_if #(.SEL_W(3), .DIV_W(8)) if8 ();
    mux_scan_sequencer_if #(.SEL_W(2), .DIV_W(8)) if4 ();

    mux_scan_sequencer #(.SEL_W(3), .DIV_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    mux_scan_sequencer #(.SEL_W(2), .DIV_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int inst, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t got=%0d expected=%0d", nm, inst, $time, got, exp);
        end
    endtask

    // Flattened views of both instances
    logic       a_lv[2], a_hold[2], a_ready[2], a_str[2], a_step[2], a_done[2], a_busy[2], a_mux[2];
    logic [7:0] a_data[2], a_div[2], a_word[2], a_sel[2];

    assign a_lv[0] = if8.load_valid;   assign a_lv[1] = if4.load_valid;
    assign a_hold[0] = if8.hold;       assign a_hold[1] = if4.hold;
    assign a_data[0] = if8.data;       assign a_data[1] = {4'b0, if4.data};
    assign a_div[0] = if8.div;         assign a_div[1] = if4.div;
    assign a_ready[0] = if8.load_ready; assign a_ready[1] = if4.load_ready;
    assign a_str[0] = if8.str;         assign a_str[1] = if4.str;
    assign a_step[0] = if8.step;       assign a_step[1] = if4.step;
    assign a_done[0] = if8.done;       assign a_done[1] = if4.done;
    assign a_busy[0] = if8.busy;       assign a_busy[1] = if4.busy;
    assign a_word[0] = if8.word;       assign a_word[1] = {4'b0, if4.word};
    assign a_sel[0] = {5'b0, if8.sel}; assign a_sel[1] = {6'b0, if4.sel};
    assign a_mux[0] = if8.str ? 1'b0 : if8.word[if8.sel];
    assign a_mux[1] = if4.str ? 1'b0 : if4.word[if4.sel];

    // Model: a scan is a count t of non-held RUN cycles; bit index = t/(D+1).
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    int       m_state[2];
    int       m_t[2];
    int       m_D[2];
    bit       m_fresh[2];
    bit [7:0] m_word[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_state[i] <= M_IDLE;
                m_t[i]     <= 0;
                m_D[i]     <= 0;
                m_fresh[i] <= 1'b0;
                m_word[i]  <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_state[i])
                    M_IDLE: if (a_lv[i]) begin
                        m_word[i]  <= a_data[i];
                        m_D[i]     <= int'(a_div[i]);
                        m_t[i]     <= 0;
                        m_fresh[i] <= 1'b1;
                        m_state[i] <= M_RUN;
                    end
                    M_RUN: if (a_hold[i]) begin
                        m_fresh[i] <= 1'b0;
                    end else begin
                        m_t[i]     <= m_t[i] + 1;
                        m_fresh[i] <= 1'b1;
                        if (m_t[i] + 1 == ((i == 0) ? 8 : 4) * (m_D[i] + 1))
                            m_state[i] <= M_DONE;
                    end
                    default: m_state[i] <= M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int run, esel;
            run  = (m_state[i] == M_RUN) ? 1 : 0;
            esel = run ? m_t[i] / (m_D[i] + 1) : 0;
            chk("sel", i, int'(a_sel[i]), esel);
            chk("str", i, int'(a_str[i]), run ? 0 : 1);
            chk("step", i, int'(a_step[i]), (run && m_fresh[i] && (m_t[i] % (m_D[i] + 1) == 0)) ? 1 : 0);
            chk("done", i, int'(a_done[i]), (m_state[i] == M_DONE) ? 1 : 0);
            chk("busy", i, int'(a_busy[i]), (m_state[i] != M_IDLE) ? 1 : 0);
            chk("load_ready", i, int'(a_ready[i]), (m_state[i] == M_IDLE) ? 1 : 0);
            chk("word", i, int'(a_word[i]), int'(m_word[i]));
            chk("mux_out", i, int'(a_mux[i]), run ? int'(m_word[i][esel]) : 0);
        end
    end

    task automatic drive(input int inst, input logic lv, input logic [7:0] d,
                         input logic [7:0] dv, input logic h);
        if (inst == 0) begin
            if8.load_valid = lv; if8.data = d; if8.div = dv; if8.hold = h;
        end else begin
            if4.load_valid = lv; if4.data = d[3:0]; if4.div = dv; if4.hold = h;
        end
    endtask

    // Accept one word, optionally hold for hl cycles from cycle hs; cycle 1 = first cycle after accept.
    task automatic scan(input int inst, input logic [7:0] d, input logic [7:0] dv,
                        input int hs, input int hl,
                        output int done_c, output logic [7:0] outs, output int sel2_len);
        int c, k;
        logic h;
        done_c = -1; outs = 8'h00; sel2_len = 0; k = 0;
        @(negedge clk);
        drive(inst, 1'b1, d, dv, 1'b0);
        @(negedge clk);
        c = 1;
        while (c < 400) begin
            if (a_step[inst] && k < 8) begin
                outs[k] = a_mux[inst];
                k++;
            end
            if (!a_str[inst] && a_sel[inst] == 8'd2) sel2_len++;
            if (a_done[inst]) begin
                done_c = c;
                break;
            end
            h = (hs > 0 && c >= hs && c < hs + hl);
            drive(inst, 1'b0, 8'($urandom), 8'($urandom), h);
            @(negedge clk);
            c++;
        end
        drive(inst, 1'b0, 8'h00, 8'h00, 1'b0);
        if (done_c < 0) chk("scan_timeout", inst, c, -1);
        @(negedge clk);
        chk("ready_after_done", inst, int'(a_ready[inst]), 1);
    endtask

    initial begin
        int       dc, s2;
        logic [7:0] outs;
        logic [7:0] hist[40];
        int       starts[4];
        int       ns;
        logic     prev_ready;
        int       done_seen;

        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 0, int'(a_ready[0]), 1);
        chk("rst_str", 0, int'(a_str[0]), 1);
        chk("rst_busy", 0, int'(a_busy[0]), 0);
        chk("rst_word", 0, int'(a_word[0]), 0);
        chk("rst_sel", 0, int'(a_sel[0]), 0);
        rst_n = 1'b1;

        // hold toggling in IDLE must not matter
        drive(0, 1'b0, 8'h00, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);

        scan(0, 8'hA5, 8'd0, 0, 0, dc, outs, s2);
        chk("a5_done_cycle", 0, dc, 9);
        chk("a5_bits", 0, int'(outs), 8'hA5);

        scan(0, 8'h3C, 8'd3, 0, 0, dc, outs, s2);
        chk("3c_done_cycle", 0, dc, 33);
        chk("3c_bits", 0, int'(outs), 8'h3C);
        chk("3c_sel2_len", 0, s2, 4);

        scan(0, 8'h5A, 8'd1, 5, 5, dc, outs, s2);
        chk("hold_done_cycle", 0, dc, 22);
        chk("hold_sel2_len", 0, s2, 7);
        chk("hold_bits", 0, int'(outs), 8'h5A);

        scan(1, 8'h09, 8'd0, 0, 0, dc, outs, s2);
        chk("w4_done_cycle", 1, dc, 5);
        chk("w4_bits", 1, int'(outs[3:0]), 4'b1001);

        // load_valid held high, data changing each cycle
        ns = 0;
        prev_ready = a_ready[0];
        for (int c = 0; c < 30; c++) begin
            if (c > 0 && a_step[0] && a_sel[0] == 8'd0 && prev_ready && ns < 4) begin
                starts[ns] = c;
                ns++;
                chk("stream_word", 0, int'(a_word[0]), int'(hist[c-1]));
            end
            prev_ready = a_ready[0];
            hist[c] = 8'($urandom);
            drive(0, 1'b1, hist[c], 8'd0, 1'b0);
            @(negedge clk);
        end
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("stream_starts", 0, ns, 3);
        if (ns >= 2) chk("stream_gap", 0, starts[1] - starts[0], 10);
        for (int c = 0; c < 20 && !a_ready[0]; c++) @(negedge clk);
        chk("stream_idle", 0, int'(a_ready[0]), 1);

        // reset in the middle of a scan
        @(negedge clk);
        drive(0, 1'b1, 8'hFF, 8'd3, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF, 8'd3, 1'b0);
        for (int c = 0; c < 40 && a_sel[0] != 8'd4; c++) @(negedge clk);
        chk("mid_sel_reached", 0, int'(a_sel[0]), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_str", 0, int'(a_str[0]), 1);
        chk("mid_rst_sel", 0, int'(a_sel[0]), 0);
        chk("mid_rst_busy", 0, int'(a_busy[0]), 0);
        chk("mid_rst_word", 0, int'(a_word[0]), 0);
        chk("mid_rst_ready", 0, int'(a_ready[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (a_done[0]) done_seen = 1;
        end
        chk("no_done_after_rst", 0, done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
